seq_detect_param: RTL and testbench

- Parametrised serial bit-pattern detector; the successor of the fixed 4-state sequence-detector FSMs in the lab set.
- Compares a 1-bit serial stream against a PAT_W-bit pattern, first bit = PATTERN MSB.
- Supports overlapping and non-overlapping detection, input qualification, and a saturating hit counter.
- Sits behind a serial receiver and drives event/interrupt logic.

---
 rtl/seq_detect_param.sv | 96 +++++++++
 tb/tb_seq_detect_param.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector: KMP-style next-state table built at
// elaboration from PATTERN, registered hit pulse and saturating hit counter.
module seq_detect_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b0110,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         clr,
    input  logic                         in_valid,
    input  logic                         in,
    output logic                         det,
    output logic [CNT_W-1:0]             det_cnt,
    output logic [$clog2(PAT_W+1)-1:0]   match_len
);

    localparam int ML_W = $clog2(PAT_W + 1);
    localparam int NENT = 2 ** (ML_W + 1);

    typedef logic [NENT-1:0][ML_W-1:0] tbl_t;

    // Entry {k, b}: longest j < PAT_W such that the first j pattern bits are a
    // suffix of (first k pattern bits, then b). This covers both a plain
    // advance and the failure chain, and on a hit yields the longest border.
    function automatic tbl_t build_next();
        tbl_t t;
        t = '0;
        for (int k = 0; k < PAT_W; k++) begin
            for (int b = 0; b < 2; b++) begin
                int best;
                best = 0;
                for (int j = 1; j < PAT_W; j++) begin
                    logic ok;
                    ok = (j <= k + 1);
                    for (int i = 0; i < j; i++) begin
                        int   p;
                        logic c;
                        p = k + 1 - j + i;
                        if (ok) begin
                            c = (p == k) ? b[0] : PATTERN[PAT_W-1-p];
                            if (PATTERN[PAT_W-1-i] != c) ok = 1'b0;
                        end
                    end
                    if (ok) best = j;
                end
                if (!OVERLAP && k == PAT_W - 1 && PATTERN[0] == b[0]) best = 0;
                t[2*k+b] = ML_W'(best);
            end
        end
        return t;
    endfunction

    localparam tbl_t NEXT = build_next();

    logic [ML_W-1:0]  match_len_q, match_len_d;
    logic             det_q, det_d;
    logic [CNT_W-1:0] det_cnt_q, det_cnt_d;
    logic             hit;

    assign hit = (match_len_q == ML_W'(PAT_W - 1)) && (in == PATTERN[0]);

    always_comb begin
        match_len_d = match_len_q;
        det_d       = 1'b0;
        det_cnt_d   = det_cnt_q;
        if (clr) begin
            match_len_d = '0;
            det_cnt_d   = '0;
        end else if (in_valid) begin
            match_len_d = NEXT[{match_len_q, in}];
            if (hit) begin
                det_d = 1'b1;
                if (det_cnt_q != {CNT_W{1'b1}}) det_cnt_d = det_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            match_len_q <= '0;
            det_q       <= 1'b0;
            det_cnt_q   <= '0;
        end else begin
            match_len_q <= match_len_d;
            det_q       <= det_d;
            det_cnt_q   <= det_cnt_d;
        end
    end

    assign det       = det_q;
    assign det_cnt   = det_cnt_q;
    assign match_len = match_len_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Five detector configurations share one stimulus stream; each is checked
// against a string-matching model plus hand-computed vectors and corner cases.
module tb_seq_detect_param;

    localparam int NC = 5;

    logic sys_clk = 1'b0;
    logic sys_rst, clr, in_valid, in;

    logic [NC-1:0]       det_w;
    logic [3:0][7:0]     cnt_w;
    logic [3:0][2:0]     ml_w;
    logic [1:0]          cnt4, ml4;

    always #5 sys_clk = ~sys_clk;

    seq_detect_param #(.PAT_W(4), .PATTERN(4'b0110), .OVERLAP(1'b1), .CNT_W(8)) u0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .clr(clr), .in_valid(in_valid), .in(in),
        .det(det_w[0]), .det_cnt(cnt_w[0]), .match_len(ml_w[0]));
    seq_detect_param #(.PAT_W(4), .PATTERN(4'b0110), .OVERLAP(1'b0), .CNT_W(8)) u1 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .clr(clr), .in_valid(in_valid), .in(in),
        .det(det_w[1]), .det_cnt(cnt_w[1]), .match_len(ml_w[1]));
    seq_detect_param #(.PAT_W(4), .PATTERN(4'b0101), .OVERLAP(1'b1), .CNT_W(8)) u2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .clr(clr), .in_valid(in_valid), .in(in),
        .det(det_w[2]), .det_cnt(cnt_w[2]), .match_len(ml_w[2]));
    seq_detect_param #(.PAT_W(4), .PATTERN(4'b0101), .OVERLAP(1'b0), .CNT_W(8)) u3 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .clr(clr), .in_valid(in_valid), .in(in),
        .det(det_w[3]), .det_cnt(cnt_w[3]), .match_len(ml_w[3]));
    seq_detect_param #(.PAT_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u4 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .clr(clr), .in_valid(in_valid), .in(in),
        .det(det_w[4]), .det_cnt(cnt4), .match_len(ml4));

    // model configuration
    int pw  [NC] = '{4, 4, 4, 4, 2};
    int pat [NC] = '{6, 6, 5, 5, 3};
    int ov  [NC] = '{1, 0, 1, 0, 1};
    int cmax[NC] = '{255, 255, 255, 255, 3};

    // model state: recent accepted bits (LSB newest) and how many are relevant
    int hv[NC], hl[NC], mcnt[NC], mdet[NC];

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit b;
        int exp_det;
        int exp_cnt;
        int exp_ml;
    } vec_t;

    function automatic int got_det(int c); return int'(det_w[c]); endfunction
    function automatic int got_cnt(int c); return (c < 4) ? int'(cnt_w[c]) : int'(cnt4); endfunction
    function automatic int got_ml(int c);  return (c < 4) ? int'(ml_w[c])  : int'(ml4);  endfunction

    function automatic int mask(int j); return (1 << j) - 1; endfunction

    function automatic int model_ml(int c);
        for (int j = pw[c] - 1; j > 0; j--)
            if (j <= hl[c] && (hv[c] & mask(j)) == ((pat[c] >> (pw[c] - j)) & mask(j)))
                return j;
        return 0;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            hv[c] = 0; hl[c] = 0; mcnt[c] = 0; mdet[c] = 0;
        end
    endtask

    task automatic model_step(input bit c_clr, input bit v, input bit b);
        for (int c = 0; c < NC; c++) begin
            mdet[c] = 0;
            if (c_clr) begin
                hv[c] = 0; hl[c] = 0; mcnt[c] = 0;
            end else if (v) begin
                hv[c] = ((hv[c] << 1) | int'(b)) & mask(pw[c]);
                hl[c] = (hl[c] < pw[c]) ? hl[c] + 1 : pw[c];
                if (hl[c] == pw[c] && hv[c] == pat[c]) begin
                    mdet[c] = 1;
                    if (mcnt[c] < cmax[c]) mcnt[c]++;
                    if (ov[c] == 0) begin hv[c] = 0; hl[c] = 0; end
                end
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        for (int c = 0; c < NC; c++) begin
            chk($sformatf("%s det%0d", tag, c), got_det(c), mdet[c]);
            chk($sformatf("%s cnt%0d", tag, c), got_cnt(c), mcnt[c]);
            chk($sformatf("%s ml%0d",  tag, c), got_ml(c),  model_ml(c));
        end
    endtask

    // inputs are changed 1 time unit after an edge, outputs sampled likewise
    task automatic step(input bit c_clr, input bit v, input bit b, input string tag);
        clr = c_clr; in_valid = v; in = b;
        @(posedge sys_clk);
        #1;
        model_step(c_clr, v, b);
        chk_model(tag);
        clr = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[8];
        bit   s2[7];
        int   pulses;

        vt[0] = '{0, 0, 0, 1}; vt[1] = '{1, 0, 0, 2};
        vt[2] = '{0, 0, 0, 1}; vt[3] = '{1, 0, 0, 2};
        vt[4] = '{0, 0, 0, 1}; vt[5] = '{1, 0, 0, 2};
        vt[6] = '{1, 0, 0, 3}; vt[7] = '{0, 1, 1, 1};
        s2 = '{0, 1, 1, 0, 1, 1, 0};

        sys_rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in = 1'b0;
        model_reset();
        repeat (3) @(posedge sys_clk);
        #1;
        chk_model("reset");
        sys_rst = 1'b0;

        // basic stream 0,1,0,1,0,1,1,0 with hand-computed expectations for 0110/overlap
        step(1, 0, 0, "clr0");
        for (int i = 0; i < 8; i++) begin
            step(0, 1, vt[i].b, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d det", i), got_det(0), vt[i].exp_det);
            chk($sformatf("tbl%0d cnt", i), got_cnt(0), vt[i].exp_cnt);
            chk($sformatf("tbl%0d ml",  i), got_ml(0),  vt[i].exp_ml);
        end
        chk("0101 ov cnt",   got_cnt(2), 2);
        chk("0101 noov cnt", got_cnt(3), 1);

        // overlapping vs non-overlapping on 0,1,1,0,1,1,0
        step(1, 0, 0, "clr1");
        for (int i = 0; i < 7; i++) step(0, 1, s2[i], $sformatf("ovl%0d", i));
        chk("ovl ov cnt",   got_cnt(0), 2);
        chk("ovl noov cnt", got_cnt(1), 1);
        chk("ovl noov ml",  got_ml(1),  1);

        // gaps between valid bits must not break the partial match
        step(1, 0, 0, "clr2");
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 1, s2[i], $sformatf("gapb%0d", i));
            pulses += got_det(0);
            if (i < 3)
                for (int g = 0; g < 3; g++) begin
                    step(0, 0, 1'($urandom_range(0, 1)), $sformatf("gap%0d_%0d", i, g));
                    pulses += got_det(0);
                    chk("gap ml hold", got_ml(0), i + 1);
                end
        end
        chk("gap pulses", pulses, 1);

        // back-to-back hits and counter saturation on 2-bit all-ones pattern
        step(1, 0, 0, "clr3");
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, $sformatf("ones%0d", i));
            pulses += got_det(4);
        end
        chk("ones pulses", pulses, 7);
        chk("ones sat", got_cnt(4), 3);

        // async reset mid-period after 0,1,1
        step(0, 1, 0, "pre0");
        step(0, 1, 1, "pre1");
        step(0, 1, 1, "pre2");
        chk("pre-rst ml", got_ml(0), 3);
        #1 sys_rst = 1'b1;
        #1;
        model_reset();
        chk_model("async rst");
        #1 sys_rst = 1'b0;
        step(0, 1, 0, "post rst");
        chk("post rst ml", got_ml(0), 1);

        // clr wins over a valid bit that would otherwise complete 0110
        step(0, 1, 1, "c1");
        step(0, 1, 1, "c2");
        chk("pre-clr ml", got_ml(0), 3);
        step(1, 1, 0, "clr hit");
        chk("clr det", got_det(0), 0);
        chk("clr ml",  got_ml(0),  0);

        // randomized run against the model
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
